// File: rtl/serial_compare_lsb.sv
// Bit-serial unsigned magnitude comparator, LSB first.
// One LT/EQ/GT verdict per WIDTH-beat frame, returned over a valid/ready stream.
module serial_compare_lsb #(
  parameter int unsigned WIDTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  output logic bit_ready,
  input  logic bit_a,
  input  logic bit_b,
  input  logic bit_last,
  input  logic abort,
  output logic res_valid,
  input  logic res_ready,
  output logic res_lt,
  output logic res_eq,
  output logic res_gt,
  output logic res_err
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ORD_EQ = 2'd0,
    ORD_LT = 2'd1,
    ORD_GT = 2'd2
  } ord_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ord_e             ord_q, ord_d;
  logic             err_q, err_d;
  logic             res_valid_q, res_valid_d;
  logic             res_lt_q, res_lt_d;
  logic             res_eq_q, res_eq_d;
  logic             res_gt_q, res_gt_d;
  logic             res_err_q, res_err_d;

  logic             beat_acc;
  logic             at_last;
  logic             frame_end;
  logic             err_beat;
  ord_e             ord_beat;

  // Accept beats only while accumulating and not held in reset
  assign bit_ready = ~rst & (state_q == S_ACCUM);
  assign beat_acc  = bit_valid & bit_ready;

  // Per-beat ordering update: later (more significant) differing bits override earlier ones
  always_comb begin
    ord_beat = ord_q;
    if (bit_a & ~bit_b) begin
      ord_beat = ORD_GT;
    end else if (~bit_a & bit_b) begin
      ord_beat = ORD_LT;
    end
  end

  assign at_last   = (cnt_q == CNT_LAST);
  assign frame_end = at_last | bit_last;
  // bit_last early, or missing on the final beat, flags a framing error
  assign err_beat  = (bit_last & ~at_last) | (~bit_last & at_last);

  // Next-state and result logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ord_d       = ord_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;
    res_lt_d    = res_lt_q;
    res_eq_d    = res_eq_q;
    res_gt_d    = res_gt_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      S_ACCUM: begin
        if (abort) begin
          cnt_d = '0;
          ord_d = ORD_EQ;
          err_d = 1'b0;
        end else if (beat_acc) begin
          cnt_d = cnt_q + CNT_W'(1);
          ord_d = ord_beat;
          err_d = err_q | err_beat;
          if (frame_end) begin
            state_d     = S_HOLD;
            res_valid_d = 1'b1;
            res_lt_d    = (ord_beat == ORD_LT);
            res_eq_d    = (ord_beat == ORD_EQ);
            res_gt_d    = (ord_beat == ORD_GT);
            res_err_d   = err_q | err_beat;
          end
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d     = S_ACCUM;
          cnt_d       = '0;
          ord_d       = ORD_EQ;
          err_d       = 1'b0;
          res_valid_d = 1'b0;
          res_lt_d    = 1'b0;
          res_eq_d    = 1'b0;
          res_gt_d    = 1'b0;
          res_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_ACCUM;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACCUM;
      cnt_q       <= '0;
      ord_q       <= ORD_EQ;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_lt_q    <= 1'b0;
      res_eq_q    <= 1'b0;
      res_gt_q    <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ord_q       <= ord_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_lt_q    <= res_lt_d;
      res_eq_q    <= res_eq_d;
      res_gt_q    <= res_gt_d;
      res_err_q   <= res_err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_lt    = res_lt_q;
  assign res_eq    = res_eq_q;
  assign res_gt    = res_gt_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_serial_compare_lsb.sv
// Testbench for serial_compare_lsb: directed frames plus randomized traffic,
// checked every cycle against an integer-level frame model.
module tb_serial_compare_lsb;

  localparam int unsigned WIDTH = 6;

  logic clk = 1'b0;
  logic rst, bit_valid, bit_a, bit_b, bit_last, abort, res_ready;
  logic bit_ready, res_valid, res_lt, res_eq, res_gt, res_err;

  int checks = 0;
  int errors = 0;

  // Frame-level model: operand values as integers, verdict by arithmetic compare
  logic m_hold, m_lt, m_eq, m_gt, m_err;
  int   m_n, m_a, m_b;

  serial_compare_lsb #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_a     (bit_a),
    .bit_b     (bit_b),
    .bit_last  (bit_last),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_lt    (res_lt),
    .res_eq    (res_eq),
    .res_gt    (res_gt),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hold = 1'b0; m_lt = 1'b0; m_eq = 1'b0; m_gt = 1'b0; m_err = 1'b0;
    m_n = 0; m_a = 0; m_b = 0;
  endtask

  // One clock: compare all outputs at negedge, advance the model, move past posedge
  task automatic step();
    logic [5:0] exp_o;
    logic [5:0] got_o;
    @(negedge clk);
    exp_o = {!rst && !m_hold, m_hold, m_lt, m_eq, m_gt, m_err};
    got_o = {bit_ready, res_valid, res_lt, res_eq, res_gt, res_err};
    check("cycle", 32'(got_o), 32'(exp_o));
    if (rst) begin
      model_clear();
    end else if (m_hold) begin
      if (res_ready) model_clear();
    end else begin
      if (bit_valid) begin
        m_a = m_a | (int'(bit_a) << m_n);
        m_b = m_b | (int'(bit_b) << m_n);
        m_n++;
      end
      if (abort) begin
        m_n = 0; m_a = 0; m_b = 0;
      end else if (bit_valid && (m_n == WIDTH || bit_last)) begin
        m_hold = 1'b1;
        m_lt   = (m_a < m_b);
        m_eq   = (m_a == m_b);
        m_gt   = (m_a > m_b);
        m_err  = !(m_n == WIDTH && bit_last);
        m_n = 0; m_a = 0; m_b = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Send n beats of a/b LSB first; bit_last on beat n if last, abort on beat abort_at
  task automatic send(input logic [5:0] a, input logic [5:0] b, input int n,
                      input logic last, input int abort_at);
    logic [5:0] av;
    logic [5:0] bv;
    av = a;
    bv = b;
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_a     = av[i];
      bit_b     = bv[i];
      bit_last  = last && (i == n - 1);
      abort     = (i == abort_at);
      step();
    end
    bit_valid = 1'b0;
    bit_last  = 1'b0;
    abort     = 1'b0;
  endtask

  function automatic logic [31:0] res_vec();
    return 32'({res_valid, res_lt, res_eq, res_gt, res_err});
  endfunction

  initial begin
    model_clear();
    rst = 1'b1; bit_valid = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
    bit_last = 1'b0; abort = 1'b0; res_ready = 1'b1;
    step();
    step();
    check("reset_out", 32'({bit_ready, res_valid, res_lt, res_eq, res_gt, res_err}), 32'h0);
    rst = 1'b0;
    step();

    // Test 1: A > B
    send(6'b010110, 6'b010011, 6, 1'b1, -1);
    check("t1_gt", res_vec(), 32'b10010);
    step();
    check("t1_drop", 32'(res_valid), 32'd0);

    // Test 2: equal operands
    send(6'h2A, 6'h2A, 6, 1'b1, -1);
    check("t2_eq", res_vec(), 32'b10100);
    step();

    // Test 3: MSB overrides earlier GT beats
    send(6'b011111, 6'b100000, 6, 1'b1, -1);
    check("t3_lt", res_vec(), 32'b11000);
    step();

    // Test 4: backpressure holds the result
    res_ready = 1'b0;
    send(6'b010110, 6'b010011, 6, 1'b1, -1);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold", res_vec(), 32'b10010);
      check("t4_noready", 32'(bit_ready), 32'd0);
      step();
    end
    res_ready = 1'b1;
    check("t4_hs", res_vec(), 32'b10010);
    step();
    check("t4_drop", res_vec(), 32'd0);

    // Test 5: early bit_last, then missing bit_last
    send(6'b000001, 6'b000100, 3, 1'b1, -1);
    check("t5_early", res_vec(), 32'b11001);
    step();
    send(6'd5, 6'd9, 6, 1'b0, -1);
    check("t5_nolast", res_vec(), 32'b11001);
    step();

    // Test 6: abort mid-frame, then a full frame
    send(6'b111111, 6'b000000, 4, 1'b0, 3);
    check("t6_abort", 32'(res_valid), 32'd0);
    send(6'd1, 6'd0, 6, 1'b1, -1);
    check("t6_gt", res_vec(), 32'b10010);
    step();
    check("t6_single", 32'(res_valid), 32'd0);

    // Reset while holding a result
    res_ready = 1'b0;
    send(6'd1, 6'd0, 6, 1'b1, -1);
    check("t7_hold", 32'(res_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_rst", res_vec(), 32'd0);
    res_ready = 1'b1;

    // Randomized traffic including aborts, stalls and occasional resets
    for (int c = 0; c < 4000; c++) begin
      bit_valid = ($urandom_range(0, 9) < 7);
      bit_a     = 1'($urandom_range(0, 1));
      bit_b     = 1'($urandom_range(0, 1));
      bit_last  = ($urandom_range(0, 9) == 0);
      abort     = ($urandom_range(0, 19) == 0);
      res_ready = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; bit_valid = 1'b0; bit_last = 1'b0; abort = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
